// File: rtl/fetch_unit_pkg.sv
// Shared constants and the bundle record for the SPU fetch path.
package descriptions;

  localparam int INST_W           = 32;
  localparam int ISSUE_WIDTH_DFLT = 2;
  localparam int PC_W             = 32;

  // Slot 0 occupies the MSBs of inst; slot_mask bit 0 is slot 0.
  typedef struct packed {
    logic [PC_W-1:0]                    pc;
    logic [ISSUE_WIDTH_DFLT*INST_W-1:0] inst;
    logic [ISSUE_WIDTH_DFLT-1:0]        slot_mask;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode bundle channel plus the redirect request from the back end.
interface fetch_unit_if #(
  parameter int ISSUE_WIDTH = descriptions::ISSUE_WIDTH_DFLT,
  parameter int INST_W      = descriptions::INST_W
);
  logic                          stall;
  logic                          redirect_valid;
  logic [31:0]                   redirect_pc;
  logic                          out_valid;
  logic [31:0]                   out_pc;
  logic [ISSUE_WIDTH*INST_W-1:0] out_inst;
  logic [ISSUE_WIDTH-1:0]        out_slot_valid;

  modport master (
    input  stall, redirect_valid, redirect_pc,
    output out_valid, out_pc, out_inst, out_slot_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_inst, out_slot_valid
  );
endinterface

// File: rtl/fetch_unit_inst_mem.sv
// Instruction ROM: returns one aligned bundle of ISSUE_WIDTH words a cycle after
// the read. Storage is image-loaded and never reset.
module inst_mem #(
  parameter int    ISSUE_WIDTH = descriptions::ISSUE_WIDTH_DFLT,
  parameter int    INST_W      = descriptions::INST_W,
  parameter int    IMEM_DEPTH  = 512,
  parameter string IMEM_FILE   = "InstructionsToBinary.txt"
) (
  input  logic                          clock,
  input  logic                          rd_en_i,
  input  logic [$clog2(IMEM_DEPTH)-1:0] rd_idx_i,
  output logic [ISSUE_WIDTH*INST_W-1:0] rd_data_o
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [INST_W-1:0] mem [IMEM_DEPTH];

  // rd_idx_i is bundle-aligned, so OR-ing the slot number selects each word.
  always_ff @(posedge clock) begin
    if (rd_en_i) begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        rd_data_o[(ISSUE_WIDTH-1-s)*INST_W +: INST_W] <= mem[rd_idx_i | AW'(s)];
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues bundle reads to inst_mem and
// buffers returned bundles in a prefetch queue presented to decode.
module fetch_unit #(
  parameter int    ISSUE_WIDTH = descriptions::ISSUE_WIDTH_DFLT,
  parameter int    INST_W      = descriptions::INST_W,
  parameter int    IMEM_DEPTH  = 512,
  parameter int    BUF_DEPTH   = 4,
  parameter string IMEM_FILE   = "InstructionsToBinary.txt"
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int B  = ISSUE_WIDTH * 4;
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(BUF_DEPTH);
  localparam int DW = ISSUE_WIDTH * INST_W;
  localparam logic [31:0]            PC_MASK    = 32'(IMEM_DEPTH * 4 - 1);
  localparam logic [31:0]            ALIGN_MASK = PC_MASK & ~32'(B - 1);
  localparam logic [ISSUE_WIDTH-1:0] ALL_SLOTS  = '1;

  typedef struct packed {
    logic [31:0]            pc;
    logic [DW-1:0]          inst;
    logic [ISSUE_WIDTH-1:0] mask;
  } bundle_t;

  logic [31:0]            fpc_q, fpc_d, rd_pc_q;
  logic [ISSUE_WIDTH-1:0] mask_q, mask_d, rd_mask_q;
  logic [QW:0]            head_q, head_d, tail_q, tail_d, count;
  logic                   inflight_q, run_q;
  logic                   issue, push, pop;
  logic [31:0]            slot_off;
  logic [DW-1:0]          rd_data;
  bundle_t                queue_q [BUF_DEPTH];
  bundle_t                head;

  assign count    = tail_q - head_q;
  assign head     = queue_q[head_q[QW-1:0]];
  assign slot_off = (bus.redirect_pc >> 2) & 32'(ISSUE_WIDTH - 1);

  // In-flight reads are charged against capacity so a return always has a slot.
  // run_q keeps the first edge after reset quiet.
  assign issue = run_q && !bus.redirect_valid
                 && ((int'(count) + int'(inflight_q)) < BUF_DEPTH);
  assign push  = inflight_q && !bus.redirect_valid;
  assign pop   = (count != '0) && !bus.stall && !bus.redirect_valid;

  always_comb begin
    fpc_d  = fpc_q;
    mask_d = mask_q;
    head_d = head_q;
    tail_d = tail_q;
    if (bus.redirect_valid) begin
      fpc_d  = bus.redirect_pc & ALIGN_MASK;
      mask_d = ALL_SLOTS << slot_off;
      head_d = tail_q;
    end else begin
      if (issue) begin
        fpc_d  = (fpc_q + 32'(B)) & PC_MASK;
        mask_d = ALL_SLOTS;
      end
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpc_q      <= '0;
      mask_q     <= ALL_SLOTS;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      rd_pc_q    <= '0;
      rd_mask_q  <= ALL_SLOTS;
    end else begin
      fpc_q      <= fpc_d;
      mask_q     <= mask_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= issue;
      run_q      <= 1'b1;
      if (issue) begin
        rd_pc_q   <= fpc_q;
        rd_mask_q <= mask_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) queue_q[tail_q[QW-1:0]] <= '{pc: rd_pc_q, inst: rd_data, mask: rd_mask_q};
  end

  inst_mem #(
    .ISSUE_WIDTH(ISSUE_WIDTH),
    .INST_W     (INST_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_FILE  (IMEM_FILE)
  ) u_mem (
    .clock    (clock),
    .rd_en_i  (issue),
    .rd_idx_i (fpc_q[2 +: AW]),
    .rd_data_o(rd_data)
  );

  always_comb begin
    bus.out_valid      = (count != '0);
    bus.out_pc         = '0;
    bus.out_inst       = '0;
    bus.out_slot_valid = '0;
    if (count != '0) begin
      bus.out_pc         = head.pc;
      bus.out_inst       = head.inst;
      bus.out_slot_valid = head.mask;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected bundle streams are queued whenever
// reset or a redirect is driven and popped as decode accepts bundles.
module tb_fetch_unit;
  import descriptions::*;

  localparam int          IW       = ISSUE_WIDTH_DFLT;
  localparam int          DEPTH    = 512;
  localparam int          BUFD     = 4;
  localparam int          BB       = IW * 4;
  localparam logic [31:0] PC_RANGE = 32'(DEPTH * 4);

  logic clock = 1'b0;
  logic reset;

  fetch_unit_if #(.ISSUE_WIDTH(IW), .INST_W(INST_W)) bus ();

  fetch_unit #(
    .ISSUE_WIDTH(IW),
    .INST_W     (INST_W),
    .IMEM_DEPTH (DEPTH),
    .BUF_DEPTH  (BUFD),
    .IMEM_FILE  ("")
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  fetch_bundle_t exp_q[$];

  function automatic logic [31:0] mem_word(input int idx);
    return {16'hC0DE, 16'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Expected stream after fetch restarts at tgt.
  task automatic sb_load(input logic [31:0] tgt, input int n);
    fetch_bundle_t b;
    logic [31:0]   pc;
    logic [IW-1:0] full;
    int            off;
    full = '1;
    exp_q.delete();
    pc  = (tgt % PC_RANGE) & ~32'(BB - 1);
    off = int'((tgt >> 2) % IW);
    for (int k = 0; k < n; k++) begin
      b.pc        = pc;
      b.slot_mask = (k == 0) ? IW'(full << off) : full;
      for (int s = 0; s < IW; s++)
        b.inst[(IW-1-s)*INST_W +: INST_W] = mem_word(int'(pc >> 2) + s);
      exp_q.push_back(b);
      pc = (pc + BB) % PC_RANGE;
    end
  endtask

  task automatic sb_monitor();
    fetch_bundle_t b;
    if (reset && bus.out_valid && !bus.stall && !bus.redirect_valid) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("sb_pc", bus.out_pc, b.pc);
        chk("sb_inst", bus.out_inst, b.inst);
        chk("sb_mask", bus.out_slot_valid, b.slot_mask);
      end
    end
  endtask

  // Monitor on the falling edge, then land 2 time units after the next rising edge.
  task automatic step();
    @(negedge clock);
    sb_monitor();
    @(posedge clock);
    #2;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) dut.u_mem.mem[i] = mem_word(i);
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step();
    step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_inst", bus.out_inst, 0);
    chk("rst_mask", bus.out_slot_valid, 0);

    sb_load(32'h0, 64);
    reset = 1'b1;
    step(); chk("boot_e0_valid", bus.out_valid, 0);
    step(); chk("boot_e1_valid", bus.out_valid, 0);
    step(); chk("boot_e2_valid", bus.out_valid, 1);
    chk("boot_e2_pc", bus.out_pc, 0);
    repeat (4) step();

    bus.stall = 1'b1;
    repeat (10) step();
    chk("stall_full", 64'(dut.count), BUFD);
    chk("stall_hold_pc", bus.out_pc, exp_q[0].pc);
    chk("stall_hold_inst", bus.out_inst, exp_q[0].inst);
    bus.stall = 1'b0;
    repeat (6) begin
      step();
      chk("refill_valid", bus.out_valid, 1);
    end

    bus.stall = 1'b1;
    repeat (6) step();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h44;
    sb_load(32'h44, 8);
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_t0_valid", bus.out_valid, 0);
    step(); chk("redir_t1_valid", bus.out_valid, 0);
    step(); chk("redir_t2_valid", bus.out_valid, 1);
    chk("redir_pc", bus.out_pc, 32'h40);
    chk("redir_mask", bus.out_slot_valid, 2'b10);
    step(); chk("redir_next_pc", bus.out_pc, 32'h48);
    chk("redir_next_mask", bus.out_slot_valid, 2'b11);
    repeat (3) step();

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    sb_load(32'h100, 8);
    step();
    bus.redirect_pc = 32'h200;
    sb_load(32'h200, 8);
    step();
    bus.redirect_valid = 1'b0;
    chk("b2b_t0_valid", bus.out_valid, 0);
    step(); chk("b2b_t1_valid", bus.out_valid, 0);
    step(); chk("b2b_t2_valid", bus.out_valid, 1);
    chk("b2b_pc", bus.out_pc, 32'h200);
    repeat (3) step();

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = PC_RANGE - 32'd8;
    sb_load(PC_RANGE - 32'd8, 8);
    step();
    bus.redirect_valid = 1'b0;
    step();
    step(); chk("wrap_pc_top", bus.out_pc, PC_RANGE - 32'd8);
    step(); chk("wrap_pc_zero", bus.out_pc, 0);
    repeat (2) step();

    bus.stall = 1'b1;
    step();
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_half_full", 64'(dut.count), BUFD / 2);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_mask", bus.out_slot_valid, 0);
    step();
    step();
    bus.stall = 1'b0;
    sb_load(32'h0, 16);
    reset = 1'b1;
    step(); chk("restart_e0_valid", bus.out_valid, 0);
    step(); chk("restart_e1_valid", bus.out_valid, 0);
    step(); chk("restart_e2_valid", bus.out_valid, 1);
    chk("restart_pc", bus.out_pc, 0);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
